// File: rtl/sda_frame_pkg.sv
// Shared types and constants for the two-source serial frame scheduler.
package sda_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_STOP_LO,
    ST_STOP_HI,
    ST_GAP
  } state_e;

  localparam logic [1:0] TAG_BTN    = 2'b10;
  localparam logic [1:0] TAG_HB     = 2'b01;
  localparam int         GAP_PHASES = 2;

endpackage

// File: rtl/sda_frame_sched_debounce.sv
// Two-flop synchronizer and level debouncer for an active-low push button;
// emits a one-cycle pulse when a press is accepted.
module button_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic press_pulse
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

  logic       r_sync0;
  logic       r_sync1;
  logic       r_stable;
  logic [7:0] r_cnt;
  logic       r_press;

  // The counter tracks how long the synchronized level has differed from the
  // accepted one; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0  <= 1'b1;
      r_sync1  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= 8'd0;
      r_press  <= 1'b0;
    end else begin
      r_sync0 <= raw_n;
      r_sync1 <= r_sync0;
      r_press <= 1'b0;
      if (r_sync1 == r_stable) begin
        r_cnt <= 8'd0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync1;
        r_cnt    <= 8'd0;
        r_press  <= ~r_sync1;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign press_pulse = r_press;

endmodule

// File: rtl/sda_frame_sched.sv
// Arbitrates button and heartbeat requests onto one bit-banged sck/sda
// transmitter: START, 8 payload bits MSB first, STOP, then a 2-phase gap.
module sda_frame_sched
  import sda_frame_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int HB_PERIOD = 2700,
  parameter int DEBOUNCE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bbutton,
  output logic       sck,
  output logic       sda,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [19:0] HB_LAST  = 20'(HB_PERIOD - 1);
  localparam logic [2:0]  GAP_LAST = 3'(GAP_PHASES - 1);

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  logic        w_btn_evt;
  logic        w_hb_evt;
  logic [19:0] r_hb_cnt;
  logic        r_pend_btn;
  logic        r_pend_hb;
  logic [7:0]  r_drop;
  logic [1:0]  w_drop_inc;

  state_e      r_state;
  state_e      w_state_n;
  logic [7:0]  r_div;
  logic [7:0]  w_div_n;
  logic        w_phase_end;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_n;
  logic [7:0]  r_payload;
  logic [7:0]  w_payload_n;
  logic [5:0]  r_seq;
  logic [5:0]  w_seq_n;
  logic        w_grant_btn;
  logic        w_grant_hb;

  logic        w_sck_n;
  logic        w_sda_n;
  logic        r_sck;
  logic        r_sda;
  logic        r_busy;

  button_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .raw_n       (bbutton),
    .press_pulse (w_btn_evt)
  );

  assign w_hb_evt    = (r_hb_cnt == HB_LAST);
  assign w_phase_end = (r_div == DIV_LAST);

  // A same-cycle event on a just-granted source re-arms it without counting a drop.
  assign w_drop_inc = {1'b0, w_btn_evt & r_pend_btn & ~w_grant_btn}
                    + {1'b0, w_hb_evt  & r_pend_hb  & ~w_grant_hb};

  always_comb begin
    w_state_n   = r_state;
    w_div_n     = r_div;
    w_bit_n     = r_bit;
    w_payload_n = r_payload;
    w_seq_n     = r_seq;
    w_grant_btn = 1'b0;
    w_grant_hb  = 1'b0;

    if (r_state != ST_IDLE) begin
      w_div_n = w_phase_end ? 8'd0 : r_div + 8'd1;
    end

    case (r_state)
      ST_IDLE: begin
        if (r_pend_btn || r_pend_hb) begin
          w_grant_btn = r_pend_btn;
          w_grant_hb  = ~r_pend_btn;
          w_state_n   = ST_START;
          w_div_n     = 8'd0;
          w_bit_n     = 3'd7;
          w_payload_n = {(r_pend_btn ? TAG_BTN : TAG_HB), r_seq};
          w_seq_n     = r_seq + 6'd1;
        end
      end
      ST_START: begin
        if (w_phase_end) w_state_n = ST_BIT_LO;
      end
      ST_BIT_LO: begin
        if (w_phase_end) w_state_n = ST_BIT_HI;
      end
      ST_BIT_HI: begin
        if (w_phase_end) begin
          if (r_bit == 3'd0) begin
            w_state_n = ST_STOP_LO;
          end else begin
            w_state_n = ST_BIT_LO;
            w_bit_n   = r_bit - 3'd1;
          end
        end
      end
      ST_STOP_LO: begin
        if (w_phase_end) w_state_n = ST_STOP_HI;
      end
      ST_STOP_HI: begin
        if (w_phase_end) begin
          w_state_n = ST_GAP;
          w_bit_n   = 3'd0;
        end
      end
      ST_GAP: begin
        if (w_phase_end) begin
          if (r_bit == GAP_LAST) w_state_n = ST_IDLE;
          else                   w_bit_n   = r_bit + 3'd1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase

    // Line levels are decoded from the state being entered so the pins
    // change on the same edge as the state register.
    w_sck_n = 1'b1;
    w_sda_n = 1'b1;
    case (w_state_n)
      ST_START:   w_sda_n = 1'b0;
      ST_BIT_LO: begin
        w_sck_n = 1'b0;
        w_sda_n = w_payload_n[w_bit_n];
      end
      ST_BIT_HI:  w_sda_n = w_payload_n[w_bit_n];
      ST_STOP_LO: begin
        w_sck_n = 1'b0;
        w_sda_n = 1'b0;
      end
      ST_STOP_HI: w_sda_n = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_div      <= 8'd0;
      r_seq      <= 6'd0;
      r_hb_cnt   <= 20'd0;
      r_pend_btn <= 1'b0;
      r_pend_hb  <= 1'b0;
      r_drop     <= 8'd0;
      r_sck      <= 1'b1;
      r_sda      <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_div      <= w_div_n;
      r_seq      <= w_seq_n;
      r_hb_cnt   <= w_hb_evt ? 20'd0 : r_hb_cnt + 20'd1;
      r_pend_btn <= w_btn_evt | (r_pend_btn & ~w_grant_btn);
      r_pend_hb  <= w_hb_evt  | (r_pend_hb  & ~w_grant_hb);
      r_drop     <= sat_add8(r_drop, w_drop_inc);
      r_sck      <= w_sck_n;
      r_sda      <= w_sda_n;
      r_busy     <= (w_state_n != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    r_bit     <= w_bit_n;
    r_payload <= w_payload_n;
  end

  assign sck      = r_sck;
  assign sda      = r_sda;
  assign busy     = r_busy;
  assign drop_cnt = r_drop;

endmodule

// File: doc/sda_frame_sched.md
SDA_FRAME_SCHED -- requirements
Module: sda_frame_sched

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per sck phase (half bit period); legal range 2..255.
REQ-002 Parameter HB_PERIOD, default 2700: clk cycles between heartbeat requests; legal range 64..2^20-1.
REQ-003 Parameter DEBOUNCE, default 16: clk cycles a synchronized button level must hold before it is accepted; legal range 2..255.
REQ-004 clk  input  1  system clock (27 MHz).
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 bbutton  input  1  raw asynchronous push button, active-low (1 = released).
REQ-007 sck  output  1  serial clock to logic-analyser header.
REQ-008 sda  output  1  serial data to logic-analyser header.
REQ-009 busy  output  1  high while a frame is on the wire, including the post-frame gap.
REQ-010 drop_cnt  output  8  saturating count of requests merged into an already-pending request.

Function
REQ-011 Two requesters SHALL share one serial transmitter: BTN (debounced bbutton press) and HB (heartbeat timer).
REQ-012 bbutton SHALL pass through a 2-FF synchronizer; a press event SHALL fire once when the synchronized level has been 0 for DEBOUNCE consecutive cycles after an accepted released state.
REQ-013 Heartbeat counter SHALL count 0..HB_PERIOD-1 continuously and raise an HB event on wrap; it is never stalled by busy.
REQ-014 Each source SHALL have a sticky pending bit set by its event and cleared on grant; an event arriving while its bit is already set SHALL increment drop_cnt (saturating at 255) and be discarded.
REQ-015 An event coinciding with the grant cycle of the same source SHALL set pending again and SHALL NOT count as a drop.
REQ-016 Grant SHALL occur only in IDLE; fixed priority BTN > HB; a losing source stays pending.
REQ-017 Payload SHALL be {tag[1:0], seq[5:0]}: tag 2'b10 for BTN, 2'b01 for HB; seq is a shared 6-bit counter incremented at each grant, wrapping 63->0.
REQ-018 A phase divider SHALL advance the FSM every CLK_DIV cycles while not in IDLE; it restarts at 0 on grant.
REQ-019 FSM states/outputs (sck,sda) per phase: IDLE (1,1); START (1,0) 1 phase; BIT_LO (0,bit) and BIT_HI (1,bit) for bits 7..0 MSB first; STOP_LO (0,0); STOP_HI (1,0); GAP (1,1) 2 phases; then IDLE.
REQ-020 A frame SHALL occupy exactly 21 phases (21*CLK_DIV cycles) from grant to IDLE; sda SHALL change only while sck is low, except the START fall and the final rise at GAP entry.
REQ-021 Grant-to-first-sda-fall latency SHALL be 1 clk cycle (registered outputs).
REQ-022 busy SHALL be high from the cycle after grant through the last GAP cycle.

Reset
REQ-023 While rst is high: sck=1, sda=1, busy=0, drop_cnt=0, seq=0, both pending bits clear, heartbeat and phase counters 0, debouncer in released state, FSM in IDLE.
REQ-024 rst asserted mid-frame SHALL abort immediately with no stop condition; the aborted frame is not retransmitted.

Structure
REQ-025 Package sda_frame_pkg SHALL hold the FSM state enum, the tag constants TAG_BTN/TAG_HB, and the GAP_PHASES constant (2).
REQ-026 Synchronizer plus debouncer SHALL be a sub-module button_debounce (clk, rst, raw_n, press_pulse).

Verification
REQ-027 CLK_DIV=4: bbutton low from cycle 100 to 150 -> one BTN frame, payload 8'h80, 84 cycles long, sck/sda pattern per REQ-019.
REQ-028 bbutton glitch low for DEBOUNCE-1 cycles -> no event, sck=sda=1 throughout.
REQ-029 Press and HB wrap in the same cycle -> BTN frame (seq 0, 8'h80) then HB frame (seq 1, 8'h41) after the 2-phase gap; drop_cnt=0.
REQ-030 HB_PERIOD=64, CLK_DIV=8 (frame 168 cycles) -> the 2nd heartbeat event during the first frame is held pending; the 3rd is dropped, drop_cnt=1.
REQ-031 rst pulsed during BIT_HI of bit 3 -> next cycle sck=1, sda=1, busy=0, seq=0; next grant sends seq 0.
REQ-032 70 heartbeat frames -> seq wraps 63->0, drop_cnt saturates at 255 when forced by 300 merged events.
